// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the frequency-counter measurement sequencer.
// Holds the sequencer state encoding, counter register map and bus command record.
package freq_meas_pkg;

  localparam logic [31:0] FM_CTRL_ADDR   = 32'h8;
  localparam logic [31:0] FM_RESULT_ADDR = 32'h9;
  localparam logic [31:0] FM_RST_CMD     = 32'h01;
  localparam logic [31:0] FM_START_CMD   = 32'h80;
  localparam int unsigned FM_MAX_RETRY   = 3;
  localparam int unsigned FM_ACK_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_RST,
    ST_WR_START,
    ST_GATE,
    ST_RD_RES,
    ST_DONE,
    ST_ERROR
  } seq_state_e;

  typedef enum logic [1:0] {
    XF_IDLE,
    XF_BUS,
    XF_GAP
  } xfer_phase_e;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
  } bus_cmd_t;

  function automatic bus_cmd_t make_cmd(input logic [31:0] adr, input logic [31:0] dat,
                                        input logic we);
    bus_cmd_t c;
    c.adr = adr;
    c.dat = dat;
    c.we  = we;
    return c;
  endfunction

endpackage

// File: rtl/freq_meas_sequencer_wb_master_xfer.sv
// Single-transfer Wishbone classic master: launches one access, handles retry and
// timeout, and reports a one-cycle done or fail pulse back to the sequencer.
module wb_master_xfer
  import freq_meas_pkg::*;
#(
  parameter int unsigned MAX_RETRY   = FM_MAX_RETRY,
  parameter int unsigned ACK_TIMEOUT = FM_ACK_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        launch_i,
  input  bus_cmd_t    cmd_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        ack_ok_o,
  output logic        done_o,
  output logic        fail_o
);

  localparam int unsigned RTY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned TMO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  xfer_phase_e      phase_q;
  bus_cmd_t         cmd_q;
  logic             bus_q;
  logic             done_q;
  logic             fail_q;
  logic [RTY_W-1:0] rty_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      phase_q   <= XF_IDLE;
      cmd_q     <= '0;
      bus_q     <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      rty_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      fail_q <= 1'b0;
      if (launch_i) begin
        phase_q   <= XF_BUS;
        cmd_q     <= cmd_i;
        bus_q     <= 1'b1;
        rty_cnt_q <= '0;
        tmo_cnt_q <= '0;
      end else begin
        case (phase_q)
          XF_BUS: begin
            // Termination priority is err > rty > ack.
            if (err_i) begin
              bus_q   <= 1'b0;
              phase_q <= XF_IDLE;
              fail_q  <= 1'b1;
            end else if (rty_i) begin
              bus_q     <= 1'b0;
              tmo_cnt_q <= '0;
              if (rty_cnt_q == RTY_LAST) begin
                phase_q <= XF_IDLE;
                fail_q  <= 1'b1;
              end else begin
                rty_cnt_q <= rty_cnt_q + RTY_W'(1);
                phase_q   <= XF_GAP;
              end
            end else if (ack_i) begin
              bus_q   <= 1'b0;
              phase_q <= XF_IDLE;
              done_q  <= 1'b1;
            end else if (tmo_cnt_q == TMO_LAST) begin
              bus_q   <= 1'b0;
              phase_q <= XF_IDLE;
              fail_q  <= 1'b1;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
          end
          XF_GAP: begin
            bus_q   <= 1'b1;
            phase_q <= XF_BUS;
          end
          default: ;
        endcase
      end
    end
  end

  assign adr_o    = cmd_q.adr;
  assign dat_o    = cmd_q.dat;
  assign we_o     = cmd_q.we;
  assign sel_o    = bus_q ? 4'hF : 4'h0;
  assign cyc_o    = bus_q;
  assign stb_o    = bus_q;
  assign ack_ok_o = (phase_q == XF_BUS) && ack_i && !err_i && !rty_i;
  assign done_o   = done_q;
  assign fail_o   = fail_q;

endmodule

// File: rtl/freq_meas_sequencer.sv
// Autonomous measurement sequencer: resets and starts the frequency counter over
// Wishbone, waits the gate time, reads the count and publishes it with a strobe.
module freq_meas_sequencer
  import freq_meas_pkg::*;
#(
  parameter logic [31:0] CTRL_ADDR   = FM_CTRL_ADDR,
  parameter logic [31:0] RESULT_ADDR = FM_RESULT_ADDR,
  parameter logic [31:0] RST_CMD     = FM_RST_CMD,
  parameter logic [31:0] START_CMD   = FM_START_CMD,
  parameter int unsigned MAX_RETRY   = FM_MAX_RETRY,
  parameter int unsigned ACK_TIMEOUT = FM_ACK_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic        continuous_i,
  input  logic        abort_i,
  input  logic [31:0] gate_cycles_i,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i,
  output logic [31:0] result_o,
  output logic        result_valid_o,
  output logic        busy_o,
  output logic        error_o
);

  seq_state_e  state_q;
  seq_state_e  state_d;
  logic        error_q;
  logic        busy_q;
  logic        valid_q;
  logic [31:0] result_q;
  logic [31:0] gate_q;
  logic [31:0] gate_cnt_q;
  logic        launch;
  bus_cmd_t    launch_cmd;
  logic        xfer_done;
  logic        xfer_fail;
  logic        xfer_ack_ok;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (start_i || (continuous_i && !abort_i && !error_q)) state_d = ST_WR_RST;
      ST_ERROR:
        if (start_i) state_d = ST_WR_RST;
      ST_WR_RST:
        if (xfer_fail) state_d = ST_ERROR;
        else if (xfer_done) state_d = abort_i ? ST_IDLE : ST_WR_START;
      ST_WR_START:
        if (xfer_fail) state_d = ST_ERROR;
        else if (xfer_done) state_d = abort_i ? ST_IDLE : ST_GATE;
      ST_GATE:
        if (abort_i) state_d = ST_IDLE;
        else if (gate_cnt_q == 32'd1) state_d = ST_RD_RES;
      ST_RD_RES:
        if (xfer_fail) state_d = ST_ERROR;
        else if (xfer_done) state_d = abort_i ? ST_IDLE : ST_DONE;
      ST_DONE:
        state_d = (continuous_i && !abort_i) ? ST_WR_RST : ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // The bus engine must raise stb on the same edge the bus state is entered.
  always_comb begin
    launch = (state_d != state_q) && (state_d inside {ST_WR_RST, ST_WR_START, ST_RD_RES});
    case (state_d)
      ST_WR_RST:   launch_cmd = make_cmd(CTRL_ADDR, RST_CMD, 1'b1);
      ST_WR_START: launch_cmd = make_cmd(CTRL_ADDR, START_CMD, 1'b1);
      ST_RD_RES:   launch_cmd = make_cmd(RESULT_ADDR, 32'h0, 1'b0);
      default:     launch_cmd = make_cmd(32'h0, 32'h0, 1'b0);
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= '0;
      gate_q     <= '0;
      gate_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      error_q <= (state_d == ST_ERROR);
      busy_q  <= (state_d != ST_IDLE) && (state_d != ST_ERROR);
      valid_q <= (state_d == ST_DONE);
      if (state_d == ST_WR_RST && state_q != ST_WR_RST)
        gate_q <= (gate_cycles_i == 32'd0) ? 32'd1 : gate_cycles_i;
      if (state_d == ST_GATE && state_q != ST_GATE)
        gate_cnt_q <= gate_q;
      else if (state_q == ST_GATE)
        gate_cnt_q <= gate_cnt_q - 32'd1;
      if (state_q == ST_RD_RES && xfer_ack_ok)
        result_q <= dat_i;
    end
  end

  wb_master_xfer #(
    .MAX_RETRY  (MAX_RETRY),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_xfer (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .launch_i(launch),
    .cmd_i   (launch_cmd),
    .ack_i   (ack_i),
    .err_i   (err_i),
    .rty_i   (rty_i),
    .adr_o   (adr_o),
    .dat_o   (dat_o),
    .we_o    (we_o),
    .sel_o   (sel_o),
    .cyc_o   (cyc_o),
    .stb_o   (stb_o),
    .ack_ok_o(xfer_ack_ok),
    .done_o  (xfer_done),
    .fail_o  (xfer_fail)
  );

  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign busy_o         = busy_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Directed bench for freq_meas_sequencer with a small configurable Wishbone slave.
// Expected values are hand-derived from the measurement timing (gate + 7 clocks).
module tb_freq_meas_sequencer;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0;
  logic        continuous_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] gate_cycles_i = 32'h0;
  logic [31:0] adr_o, dat_o, dat_i, result_o;
  logic        we_o, cyc_o, stb_o, ack_i, err_i, rty_i;
  logic [3:0]  sel_o;
  logic        result_valid_o, busy_o, error_o;

  logic        no_ack_read = 1'b0;
  logic        err_force = 1'b0;
  logic [31:0] read_data = 32'h1F4;
  int          rty_limit = 0;
  int          rty_given = 0;
  int          cyc_cnt = 0;
  int          stb_read_cnt = 0;
  int          gap_bad = 0;
  int          chk_stage = 0;
  int          log_n = 0;
  logic [31:0] log_adr[64];
  logic [31:0] log_dat[64];
  logic        log_we[64];
  int          n_checks = 0;
  int          n_fail = 0;

  freq_meas_sequencer dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .continuous_i(continuous_i),
    .abort_i(abort_i), .gate_cycles_i(gate_cycles_i), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i), .result_o(result_o),
    .result_valid_o(result_valid_o), .busy_o(busy_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  assign err_i = stb_o && err_force;
  assign rty_i = stb_o && we_o && (dat_o == 32'h80) && (rty_given < rty_limit);
  assign ack_i = stb_o && !rty_i && !err_i && !(no_ack_read && !we_o);
  assign dat_i = (stb_o && !we_o) ? read_data : 32'h0;

  always @(posedge clk_i) begin
    cyc_cnt <= cyc_cnt + 1;
    if (stb_o && rty_i) rty_given <= rty_given + 1;
  end

  always @(negedge clk_i) begin
    if (chk_stage == 1) begin
      if (stb_o !== 1'b0) gap_bad++;
      chk_stage = 2;
    end else if (chk_stage == 2) begin
      if (stb_o !== 1'b1) gap_bad++;
      chk_stage = 0;
    end
    if (stb_o && rty_i) chk_stage = 1;
    if (stb_o && !we_o) stb_read_cnt++;
    if (stb_o && ack_i) begin
      if (log_n < 64) begin
        log_adr[log_n] = adr_o;
        log_dat[log_n] = we_o ? dat_o : dat_i;
        log_we[log_n]  = we_o;
      end
      $display("[%0d] bus %s adr=0x%0h dat=0x%0h", cyc_cnt, we_o ? "WR" : "RD", adr_o,
               we_o ? dat_o : dat_i);
      log_n++;
    end
  end

  task automatic pulse_start(input logic [31:0] gate, output int t0);
    @(negedge clk_i);
    gate_cycles_i = gate;
    start_i = 1'b1;
    t0 = cyc_cnt;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int t, output bit ok);
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (result_valid_o === 1'b1) begin
        ok = 1'b1;
        t = cyc_cnt;
        break;
      end
    end
  endtask

  task automatic wait_busy_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (busy_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] idle_word;
    rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    idle_word = {result_o[29:0], busy_o, cyc_o} | {stb_o, error_o, result_valid_o, we_o, 28'h0};
    n_checks++;
    if (idle_word !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: got 0x%0h expected 0x0", idle_word);
    end
    n_checks++;
    if (sel_o !== 4'h0 || adr_o !== 32'h0 || dat_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: got sel=%h adr=%h dat=%h expected all 0", sel_o, adr_o, dat_o);
    end
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b0 || stb_o !== 1'b0 || result_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_idle: got busy=%b stb=%b result=%h expected 0/0/0", busy_o, stb_o, result_o);
    end
  endtask

  task automatic test_single;
    int t0, tv, lb;
    bit ok;
    lb = log_n;
    read_data = 32'h1F4;
    pulse_start(32'd100, t0);
    wait_valid(300, tv, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_valid_seen: got none expected pulse"); end
    n_checks++;
    if (tv - t0 !== 107) begin n_fail++; $display("FAIL single_latency: got %0d expected 107", tv - t0); end
    n_checks++;
    if (result_o !== 32'h1F4) begin n_fail++; $display("FAIL single_result: got 0x%0h expected 0x1f4", result_o); end
    @(negedge clk_i);
    n_checks++;
    if (result_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL single_after_done: got valid=%b busy=%b expected 0/0", result_valid_o, busy_o);
    end
    n_checks++;
    if (log_n - lb !== 3) begin n_fail++; $display("FAIL single_xfer_count: got %0d expected 3", log_n - lb); end
    n_checks++;
    if (log_adr[lb] !== 32'h8 || log_dat[lb] !== 32'h01 || log_we[lb] !== 1'b1) begin
      n_fail++; $display("FAIL single_xfer0: got %h/%h/%b expected 8/1/1", log_adr[lb], log_dat[lb], log_we[lb]);
    end
    n_checks++;
    if (log_adr[lb+1] !== 32'h8 || log_dat[lb+1] !== 32'h80 || log_we[lb+1] !== 1'b1) begin
      n_fail++; $display("FAIL single_xfer1: got %h/%h/%b expected 8/80/1", log_adr[lb+1], log_dat[lb+1], log_we[lb+1]);
    end
    n_checks++;
    if (log_adr[lb+2] !== 32'h9 || log_we[lb+2] !== 1'b0 || error_o !== 1'b0) begin
      n_fail++; $display("FAIL single_xfer2: got adr=%h we=%b err=%b expected 9/0/0", log_adr[lb+2], log_we[lb+2], error_o);
    end
  endtask

  task automatic test_gate_zero;
    int t0, tv;
    bit ok;
    read_data = 32'h33;
    pulse_start(32'd0, t0);
    wait_valid(50, tv, ok);
    n_checks++;
    if (!ok || tv - t0 !== 8) begin n_fail++; $display("FAIL gate_zero_latency: got %0d ok=%b expected 8", tv - t0, ok); end
    n_checks++;
    if (result_o !== 32'h33) begin n_fail++; $display("FAIL gate_zero_result: got 0x%0h expected 0x33", result_o); end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_continuous;
    int t0, nv, busy_low, extra, lb;
    int vt[3];
    lb = log_n;
    read_data = 32'h77;
    nv = 0; busy_low = 0; extra = 0;
    @(negedge clk_i);
    gate_cycles_i = 32'd10;
    continuous_i = 1'b1;
    start_i = 1'b1;
    t0 = cyc_cnt;
    for (int i = 0; i < 120 && nv < 3; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (busy_o !== 1'b1) busy_low++;
      if (result_valid_o === 1'b1) begin vt[nv] = cyc_cnt; nv++; end
    end
    continuous_i = 1'b0;
    n_checks++;
    if (nv !== 3) begin n_fail++; $display("FAIL cont_pulses: got %0d expected 3", nv); end
    n_checks++;
    if (vt[0] - t0 !== 17) begin n_fail++; $display("FAIL cont_first_latency: got %0d expected 17", vt[0] - t0); end
    n_checks++;
    if (vt[1] - vt[0] !== 17 || vt[2] - vt[1] !== 17) begin
      n_fail++; $display("FAIL cont_period: got %0d,%0d expected 17,17", vt[1] - vt[0], vt[2] - vt[1]);
    end
    n_checks++;
    if (busy_low !== 0) begin n_fail++; $display("FAIL cont_no_idle: got %0d idle cycles expected 0", busy_low); end
    @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL cont_stop: got busy=%b expected 0", busy_o); end
    repeat (30) begin
      @(negedge clk_i);
      if (result_valid_o === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0 || log_n - lb !== 9) begin
      n_fail++; $display("FAIL cont_after_stop: got extra=%0d xfers=%0d expected 0/9", extra, log_n - lb);
    end
  endtask

  task automatic test_retry;
    int t0, tv, rb, gb;
    bit ok;
    read_data = 32'h5A;
    rb = rty_given; gb = gap_bad;
    rty_limit = rty_given + 2;
    pulse_start(32'd5, t0);
    wait_valid(100, tv, ok);
    n_checks++;
    if (!ok || tv - t0 !== 16) begin n_fail++; $display("FAIL retry2_latency: got %0d ok=%b expected 16", tv - t0, ok); end
    n_checks++;
    if (rty_given - rb !== 2 || gap_bad - gb !== 0) begin
      n_fail++; $display("FAIL retry2_gaps: got rty=%0d badgaps=%0d expected 2/0", rty_given - rb, gap_bad - gb);
    end
    n_checks++;
    if (error_o !== 1'b0 || result_o !== 32'h5A) begin
      n_fail++; $display("FAIL retry2_result: got err=%b res=0x%0h expected 0/0x5a", error_o, result_o);
    end
    repeat (2) @(negedge clk_i);
    rb = rty_given;
    rty_limit = rty_given + 4;
    pulse_start(32'd5, t0);
    wait_busy_low(100, ok);
    n_checks++;
    if (!ok || error_o !== 1'b1 || cyc_o !== 1'b0) begin
      n_fail++; $display("FAIL retry4_error: got ok=%b err=%b cyc=%b expected 1/1/0", ok, error_o, cyc_o);
    end
    n_checks++;
    if (rty_given - rb !== 4) begin n_fail++; $display("FAIL retry4_count: got %0d expected 4", rty_given - rb); end
    rty_limit = rty_given;
    continuous_i = 1'b1;
    repeat (5) @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b0 || error_o !== 1'b1) begin
      n_fail++; $display("FAIL error_ignores_cont: got busy=%b err=%b expected 0/1", busy_o, error_o);
    end
    continuous_i = 1'b0;
  endtask

  task automatic test_timeout;
    int t0, tv, sb;
    bit ok;
    sb = stb_read_cnt;
    no_ack_read = 1'b1;
    pulse_start(32'd3, t0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (error_o === 1'b1) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || busy_o !== 1'b0) begin n_fail++; $display("FAIL timeout_error: got ok=%b busy=%b expected 1/0", ok, busy_o); end
    n_checks++;
    if (stb_read_cnt - sb !== 16) begin n_fail++; $display("FAIL timeout_stb_len: got %0d expected 16", stb_read_cnt - sb); end
    no_ack_read = 1'b0;
    read_data = 32'h2A5;
    pulse_start(32'd3, t0);
    n_checks++;
    if (error_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL timeout_restart: got err=%b busy=%b expected 0/1", error_o, busy_o);
    end
    wait_valid(100, tv, ok);
    n_checks++;
    if (!ok || result_o !== 32'h2A5) begin n_fail++; $display("FAIL timeout_rerun: got ok=%b res=0x%0h expected 1/0x2a5", ok, result_o); end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_abort;
    int t0, lb, nval;
    lb = log_n;
    nval = 0;
    read_data = 32'hABC;
    pulse_start(32'd50, t0);
    repeat (10) @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b expected 0", busy_o); end
    abort_i = 1'b0;
    repeat (80) begin
      @(negedge clk_i);
      if (result_valid_o === 1'b1) nval++;
    end
    n_checks++;
    if (nval !== 0 || result_o !== 32'h2A5) begin
      n_fail++; $display("FAIL abort_no_result: got pulses=%0d res=0x%0h expected 0/0x2a5", nval, result_o);
    end
    n_checks++;
    if (log_n - lb !== 2 || error_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_read: got xfers=%0d err=%b expected 2/0", log_n - lb, error_o);
    end
  endtask

  task automatic test_err;
    int t0, lb;
    bit ok;
    lb = log_n;
    err_force = 1'b1;
    pulse_start(32'd5, t0);
    wait_busy_low(20, ok);
    n_checks++;
    if (!ok || error_o !== 1'b1 || log_n - lb !== 0) begin
      n_fail++; $display("FAIL err_term: got ok=%b err=%b xfers=%0d expected 1/1/0", ok, error_o, log_n - lb);
    end
    err_force = 1'b0;
  endtask

  task automatic test_async_reset;
    int t0;
    bit ok;
    pulse_start(32'd5, t0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (stb_o === 1'b1 && dat_o === 32'h80) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
    n_checks++;
    if (!ok || sel_o !== 4'hF) begin n_fail++; $display("FAIL arst_reach_start: got ok=%b sel=%h expected 1/f", ok, sel_o); end
    #2 rstn_i = 1'b0;
    #1;
    n_checks++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0 || busy_o !== 1'b0 || sel_o !== 4'h0) begin
      n_fail++; $display("FAIL arst_immediate: got cyc=%b stb=%b busy=%b sel=%h expected 0/0/0/0", cyc_o, stb_o, busy_o, sel_o);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b0 || error_o !== 1'b0 || result_o !== 32'h0) begin
      n_fail++; $display("FAIL arst_after: got busy=%b err=%b res=0x%0h expected 0/0/0", busy_o, error_o, result_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gate_zero();
    test_continuous();
    test_retry();
    test_timeout();
    test_abort();
    test_err();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
